data_sram_responder: RTL



---
 rtl/data_sram_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder
// Responder end of the SRAM-like data bus. Requests are accepted with a
// same-cycle addr_ok, the word-addressed RAM is read or written at
// acceptance, and responses return in order on data_ok/rdata a fixed number
// of cycles later. An optional LFSR throttles addr_ok to exercise the
// initiator's stall handling.
module data_sram_responder #(
  parameter int          MEM_AW       = 10,
  parameter int          DEPTH        = 2,
  parameter int          RESP_LATENCY = 1,
  parameter int          STALL_EN     = 0,
  parameter logic [15:0] STALL_MASK   = 16'h0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS = 1 << MEM_AW;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  logic [31:0]   r_mem    [WORDS];
  logic [31:0]   r_q_data [DEPTH];
  logic [CW-1:0] r_q_cnt  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [OW-1:0] r_occ;
  logic [15:0]   r_lfsr;

  logic [MEM_AW-1:0] w_idx;
  logic [31:0]       w_rd_word;
  logic              w_stall;
  logic              w_deq;
  logic              w_acc;
  logic              w_unused;

  // Transfer size is informational only and the address bits outside the
  // word index are ignored, so out-of-range addresses alias.
  assign w_unused  = ^{size, addr[31:MEM_AW+2], addr[1:0]};

  assign w_idx     = addr[MEM_AW+1:2];
  assign w_rd_word = r_mem[w_idx];

  assign w_stall   = (STALL_EN != 0) && ((r_lfsr & STALL_MASK) != 16'd0);
  assign w_deq     = (r_occ != '0) && (r_q_cnt[r_head] == '0);

  // A full queue can still accept when its head leaves in the same cycle.
  // Reset blocks acceptance so no RAM write or enqueue slips through it.
  assign addr_ok   = req & ~reset & ~w_stall & ((r_occ < OW'(DEPTH)) | w_deq);
  assign w_acc     = addr_ok;

  assign data_ok   = w_deq;
  assign rdata     = w_deq ? r_q_data[r_head] : 32'd0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  // Stall pattern generator: 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  // Backing RAM: byte-lane store on acceptance; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_acc && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Response queue: age pending entries, enqueue on accept, dequeue on data_ok.
  // Aging stale slots is harmless because enqueue overwrites the countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q_cnt[i] != '0) r_q_cnt[i] <= r_q_cnt[i] - 1'b1;
      end
      if (w_acc) begin
        r_q_cnt[r_tail]  <= CW'(RESP_LATENCY - 1);
        r_q_data[r_tail] <= wr ? 32'd0 : w_rd_word;
        r_tail           <= ptr_inc(r_tail);
      end
      if (w_deq) r_head <= ptr_inc(r_head);
      case ({w_acc, w_deq})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
